// File: rtl/alu_cmd_ctrl.sv
// Command FIFO and issue/capture/respond sequencer in front of a registered 36-bit ALU.
// One command is in flight at a time; responses carry the tag back in acceptance order.
module alu_cmd_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [35:0]     cmd_a,
  input  logic [35:0]     cmd_b,
  input  logic [TAGW-1:0] cmd_tag,
  output logic [1:0]      alu_op,
  output logic [35:0]     alu_a,
  output logic [35:0]     alu_b,
  input  logic [35:0]     alu_y,
  input  logic            alu_error,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [35:0]     rsp_y,
  output logic            rsp_error,
  output logic [TAGW-1:0] rsp_tag,
  output logic            busy,
  output logic [7:0]      err_cnt
);

  localparam int unsigned DW = 36;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [1:0]      op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [TAGW-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [DW-1:0]   rsp_y_q, rsp_y_d;
  logic            rsp_err_q, rsp_err_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            push, pop, fifo_empty;
  cmd_t            head, wr_data;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q < CW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rd_ptr_q];
  assign wr_data    = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};

  // FIFO storage needs no reset: only entries below count_q are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so increment wraps modulo DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Next-state, pop decision and datapath next values
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    tag_d     = tag_q;
    rsp_y_d   = rsp_y_q;
    rsp_err_d = rsp_err_q;
    rsp_tag_d = rsp_tag_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        state_d   = S_RESP;
        rsp_y_d   = alu_y;
        rsp_err_d = alu_error;
        rsp_tag_d = tag_q;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (rsp_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (pop) begin
      alu_op_d = head.op;
      alu_a_d  = head.a;
      alu_b_d  = head.b;
      tag_d    = head.tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      tag_q     <= '0;
      rsp_y_q   <= '0;
      rsp_err_q <= 1'b0;
      rsp_tag_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      tag_q     <= tag_d;
      rsp_y_q   <= rsp_y_d;
      rsp_err_q <= rsp_err_d;
      rsp_tag_q <= rsp_tag_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_y     = rsp_y_q;
  assign rsp_error = rsp_err_q;
  assign rsp_tag   = rsp_tag_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the command FIFO depth in entries (power of two, >= 2).
REQ-002 The block SHALL have parameter TAGW, default 4, the width of the command/response tag.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock, all state on its rising edge.
- reset  in  1  asynchronous, active-low: 0 resets.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  0 add, 1 sub, 2 mult, 3 div.
- cmd_a  in  36  signed operand A.
- cmd_b  in  36  signed operand B.
- cmd_tag  in  TAGW  opaque ID, returned unchanged.
- alu_op  out  2  op presented to the downstream ALU.
- alu_a  out  36  operand A to the ALU.
- alu_b  out  36  operand B to the ALU.
- alu_y  in  36  ALU registered result.
- alu_error  in  1  ALU registered error flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_y  out  36  result.
- rsp_error  out  1  error flag.
- rsp_tag  out  TAGW  tag of the completed command.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- err_cnt  out  8  count of error responses.

Function
REQ-004 A command SHALL be pushed into the FIFO on an edge where cmd_valid=1 and cmd_ready=1.
REQ-005 cmd_ready SHALL equal (FIFO count < DEPTH), combinationally from registered count only; there is no bypass path.
REQ-006 The FSM SHALL have the states IDLE, ISSUE, CAPT and RESP.
REQ-007 IDLE with FIFO non-empty -> pop head into alu_op/alu_a/alu_b and a held tag register, next state ISSUE; IDLE with FIFO empty -> stay in IDLE.
REQ-008 ISSUE -> CAPT unconditionally; the ALU registers the operands at this edge.
REQ-009 CAPT -> RESP unconditionally, capturing alu_y into rsp_y and alu_error into rsp_error.
REQ-010 rsp_valid SHALL be 1 exactly in RESP; rsp_y, rsp_error and rsp_tag SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-011 RESP with rsp_ready=1 -> ISSUE with a new pop if the FIFO is non-empty, else -> IDLE.
REQ-012 alu_op, alu_a and alu_b SHALL change only on a pop and otherwise hold their last value.
REQ-013 Latency: a command accepted at edge t into an empty FIFO while IDLE SHALL give rsp_valid=1 after edge t+3.
REQ-014 Throughput SHALL be one command per 3 cycles when rsp_ready is held at 1.
REQ-015 Responses SHALL come out in acceptance order.
REQ-016 A push and a pop on the same edge SHALL leave the count unchanged.
REQ-017 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-018 err_cnt SHALL increment on each edge where rsp_valid=1, rsp_ready=1 and rsp_error=1, and SHALL saturate at 255.
REQ-019 busy SHALL be 1 when the FIFO count != 0 or the state != IDLE.

Reset
REQ-020 While reset=0, asynchronously and regardless of clk:
- FIFO emptied, state IDLE.
- cmd_ready=1, rsp_valid=0.
- rsp_y=0, rsp_error=0, rsp_tag=0.
- alu_op=0, alu_a=0, alu_b=0.
- err_cnt=0, busy=0.
REQ-021 Reset asserted mid-operation SHALL discard all queued and in-flight commands, with no response produced for them.
REQ-022 The first edge after reset deassertion SHALL accept a command normally.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Add, op=0, A=5, B=7, tag=3, rsp_ready=1 -> rsp_valid 3 cycles after acceptance; rsp_y=12, rsp_error=0, rsp_tag=3.
- Mult, op=2, A=-3, B=4 -> rsp_y=36'hF_FFFF_FFF4, rsp_error=0.
- Div by zero, op=3, A=9, B=0 -> rsp_y=0, rsp_error=1; err_cnt goes 0->1 on the handshake edge.
- Backpressure with rsp_ready=0, 6 back-to-back commands -> first reaches RESP, next 4 fill the FIFO, cmd_ready=0 for the 6th. Then release rsp_ready -> all responses in order with tags intact, cmd_ready reasserts.
- Reset pulse while in CAPT with 2 commands queued -> rsp_valid=0, busy=0, err_cnt=0 immediately; no stale response after release.
- 300 div-by-zero commands -> err_cnt saturates at 255.
